vga_timing_gen: RTL

//  Parametrised VGA raster timing generator: pixel strobe from the system clock, hc/vc counters,

---
 rtl/vga_timing_pkg.sv | 35 +++
 rtl/vga_timing_gen_if.sv | 33 +++
 rtl/vga_pix_strobe.sv | 28 ++
 rtl/vga_timing_gen.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// VGA raster timing constants and helpers shared by the timing generator.
// Defaults describe 640x480@60 on an 800x525 raster from a 50 MHz clock.
package vga_timing_pkg;

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    localparam int H_ACTIVE_640 = 640;
    localparam int H_FP_640     = 16;
    localparam int H_SYNC_640   = 96;
    localparam int H_BP_640     = 48;

    localparam int V_ACTIVE_480 = 480;
    localparam int V_FP_480     = 10;
    localparam int V_SYNC_480   = 2;
    localparam int V_BP_480     = 33;

    localparam int CLK_DIV_DEF = 2;
    localparam int CW_DEF      = 10;
    localparam int FRAME_W_DEF = 8;

    function automatic int raster_total(
        input int act,
        input int fp,
        input int sync,
        input int bp
    );
        return act + fp + sync + bp;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator and its consumers.
// The generator owns everything except the run enable.
interface vga_timing_gen_if
    import vga_timing_pkg::*;
#(
    parameter int CW      = CW_DEF,
    parameter int FRAME_W = FRAME_W_DEF
);

    logic               en;
    logic [CW-1:0]      hc;
    logic [CW-1:0]      vc;
    logic               hsync;
    logic               vsync;
    logic               active;
    logic               pix_en;
    logic               line_start;
    logic               frame_start;
    logic [FRAME_W-1:0] frame_cnt;

    modport master (
        input  en,
        output hc, vc, hsync, vsync, active,
        output pix_en, line_start, frame_start, frame_cnt
    );

    modport slave (
        output en,
        input  hc, vc, hsync, vsync, active,
        input  pix_en, line_start, frame_start, frame_cnt
    );

endinterface

// File: rtl/vga_pix_strobe.sv
// Pixel-rate divider: flags the clk edge on which a new pixel begins.
// The phase only advances while enabled, so a pause resumes mid-pixel.
module vga_pix_strobe #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q;

    assign tick = en && (div_q == LAST);

    // count clk cycles within the current pixel, frozen when disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else if (en) begin
            div_q <= (div_q == LAST) ? '0 : div_q + DW'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: hc/vc counters, registered syncs/blanking,
// one-clk pixel/line/frame strobes and a completed-frame counter.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_640,
    parameter int   H_FP     = H_FP_640,
    parameter int   H_SYNC   = H_SYNC_640,
    parameter int   H_BP     = H_BP_640,
    parameter int   V_ACTIVE = V_ACTIVE_480,
    parameter int   V_FP     = V_FP_480,
    parameter int   V_SYNC   = V_SYNC_480,
    parameter int   V_BP     = V_BP_480,
    parameter logic HS_POL   = SYNC_ACTIVE_LOW,
    parameter logic VS_POL   = SYNC_ACTIVE_LOW,
    parameter int   CLK_DIV  = CLK_DIV_DEF,
    parameter int   CW       = CW_DEF,
    parameter int   FRAME_W  = FRAME_W_DEF
) (
    input logic              clk,
    input logic              rst,
    vga_timing_gen_if.master bus
);

    localparam int H_TOTAL = raster_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = raster_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int CX      = CW + 1;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    // one spare bit so a sync window ending exactly at 2**CW still fits
    localparam logic [CX-1:0] H_ACT_END = CX'(H_ACTIVE);
    localparam logic [CX-1:0] V_ACT_END = CX'(V_ACTIVE);
    localparam logic [CX-1:0] HS_BEG    = CX'(H_ACTIVE + H_FP);
    localparam logic [CX-1:0] HS_END    = CX'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CX-1:0] VS_BEG    = CX'(V_ACTIVE + V_FP);
    localparam logic [CX-1:0] VS_END    = CX'(V_ACTIVE + V_FP + V_SYNC);

    if ((1 << CW) < max2(H_TOTAL, V_TOTAL)) begin : g_cw_check
        $error("vga_timing_gen: CW too narrow for the raster size");
    end

    if (CLK_DIV < 1) begin : g_div_check
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end

    logic               tick;
    logic [CW-1:0]      hc_q;
    logic [CW-1:0]      vc_q;
    logic [CW-1:0]      hc_nxt;
    logic [CW-1:0]      vc_nxt;
    logic [CX-1:0]      hc_x;
    logic [CX-1:0]      vc_x;
    logic               hs_on;
    logic               vs_on;
    logic               act_on;
    logic               top_left;
    logic               hs_q;
    logic               vs_q;
    logic               act_q;
    logic               pix_q;
    logic               ls_q;
    logic               fs_q;
    logic [FRAME_W-1:0] fc_q;

    vga_pix_strobe #(
        .CLK_DIV (CLK_DIV)
    ) u_strobe (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.en),
        .tick (tick)
    );

    // next raster position; only moves on a pixel edge
    always_comb begin
        hc_nxt = hc_q;
        vc_nxt = vc_q;
        if (tick) begin
            if (hc_q == H_LAST) begin
                hc_nxt = '0;
                vc_nxt = (vc_q == V_LAST) ? '0 : vc_q + CW'(1);
            end else begin
                hc_nxt = hc_q + CW'(1);
            end
        end
    end

    assign hc_x     = {1'b0, hc_nxt};
    assign vc_x     = {1'b0, vc_nxt};
    assign hs_on    = (hc_x >= HS_BEG) && (hc_x < HS_END);
    assign vs_on    = (vc_x >= VS_BEG) && (vc_x < VS_END);
    assign act_on   = (hc_x < H_ACT_END) && (vc_x < V_ACT_END);
    assign top_left = (hc_nxt == '0) && (vc_nxt == '0);

    // position, decoded levels and frame count change on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hc_q  <= H_LAST;
            vc_q  <= V_LAST;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            act_q <= 1'b0;
            fc_q  <= '1;
        end else if (tick) begin
            hc_q  <= hc_nxt;
            vc_q  <= vc_nxt;
            hs_q  <= hs_on ? HS_POL : ~HS_POL;
            vs_q  <= vs_on ? VS_POL : ~VS_POL;
            act_q <= act_on;
            if (top_left) begin
                fc_q <= fc_q + FRAME_W'(1);
            end
        end
    end

    // strobes are high for the single clk following each pixel edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_q <= 1'b0;
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            pix_q <= tick;
            ls_q  <= tick && (hc_nxt == '0);
            fs_q  <= tick && top_left;
        end
    end

    assign bus.hc          = hc_q;
    assign bus.vc          = vc_q;
    assign bus.hsync       = hs_q;
    assign bus.vsync       = vs_q;
    assign bus.active      = act_q;
    assign bus.pix_en      = pix_q;
    assign bus.line_start  = ls_q;
    assign bus.frame_start = fs_q;
    assign bus.frame_cnt   = fc_q;

endmodule
